// File: rtl/uart_fifo_pkg.sv
// Shared constants for the UART transmit FIFO: default depth and the bit
// positions used when the FIFO status is packed into the status register.
package uart_fifo_pkg;

  localparam int DEPTH_LOG2_DEFAULT = 4;

  // Status register layout.
  localparam int STAT_EMPTY_BIT  = 0;
  localparam int STAT_FULL_BIT   = 1;
  localparam int STAT_OVF_BIT    = 2;
  localparam int STAT_LWM_BIT    = 3;
  localparam int STAT_LEVEL_LSB  = 8;
  localparam int STAT_LEVEL_MSB  = 15;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the transmit FIFO: synchronous write, asynchronous read,
// so the head byte is presented to the UART core without a read cycle.
module uart_fifo_mem
  import uart_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [7:0]            rdata
);

  logic [7:0] mem [2**DEPTH_LOG2];

  // Write port.
  // NOTE: storage has no reset; empty/full come from the reset pointers and
  // count, so the contents are never observed before they are written.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO sitting in front of the simpleuart_div16 data-register port.
// Bytes are pushed at bus speed and drained one per completed frame through
// the reg_dat_we/reg_dat_di/reg_dat_wait handshake.
// Optional low-watermark interrupt: define UART_TX_FIFO_LWM_EN.
module uart_tx_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
  parameter int LWM_RESET  = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                uart_enabled,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  input  logic                flush,
  input  logic                clr_ovf,
`ifdef UART_TX_FIFO_LWM_EN
  input  logic                lwm_we,
  input  logic [DEPTH_LOG2:0] lwm_di,
`endif
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  output logic                uart_dat_we,
  output logic [31:0]         uart_dat_di,
  input  logic                uart_dat_wait,
  output logic                lwm_irq
);

  localparam int                DEPTH     = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [7:0]            head_byte;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Status derived purely from the registered count.
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign level = count;

  // Handshake qualifiers; flush overrides any push, and a push during flush
  // is discarded silently rather than counted as an overflow.
  assign uart_dat_we = !empty && uart_enabled;
  assign pop         = uart_dat_we && !uart_dat_wait;
  assign push        = wr_en && !full && !flush;
  assign drop        = wr_en &&  full && !flush;

  // Head byte is forced to zero while empty so the core never sees stale data.
  assign uart_dat_di = empty ? 32'h0 : {24'h0, head_byte};

  uart_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (head_byte)
  );

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a dropped push beats a simultaneous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

`ifdef UART_TX_FIFO_LWM_EN
  logic [DEPTH_LOG2:0] lwm;

  // Programmable low-watermark threshold and its level interrupt.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lwm     <= LWM_RESET[DEPTH_LOG2:0];
      lwm_irq <= 1'b0;
    end else begin
      if (lwm_we) lwm <= lwm_di;
      lwm_irq <= (count <= lwm) && uart_enabled;
    end
  end
`else
  assign lwm_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based reference model updated on each clock
// edge, a monitor comparing every output on the falling edge, directed
// scenarios followed by a randomized phase with flushes and a mid-run reset.
module tb_uart_tx_fifo;

  localparam int DL    = 4;
  localparam int DEPTH = 2**DL;

  logic          clk = 1'b0;
  logic          resetn;
  logic          uart_enabled;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          clr_ovf;
  logic          lwm_we;
  logic [DL:0]   lwm_di;
  logic          full;
  logic          empty;
  logic [DL:0]   level;
  logic          overflow;
  logic          uart_dat_we;
  logic [31:0]   uart_dat_di;
  logic          uart_dat_wait;
  logic          lwm_irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [7:0] m_q[$];
  bit         m_ovf;
  bit         m_lwm_irq;
  int         m_lwm;
  logic [7:0] tx_log[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH_LOG2(DL), .LWM_RESET(0)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .uart_enabled  (uart_enabled),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .flush         (flush),
    .clr_ovf       (clr_ovf),
`ifdef UART_TX_FIFO_LWM_EN
    .lwm_we        (lwm_we),
    .lwm_di        (lwm_di),
`endif
    .full          (full),
    .empty         (empty),
    .level         (level),
    .overflow      (overflow),
    .uart_dat_we   (uart_dat_we),
    .uart_dat_di   (uart_dat_di),
    .uart_dat_wait (uart_dat_wait),
    .lwm_irq       (lwm_irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // Reference model: a queue of pending bytes evolved from the inputs seen at each edge.
  always @(posedge clk or negedge resetn) begin
    int n;
    if (!resetn) begin
      m_q.delete();
      m_ovf     = 1'b0;
      m_lwm_irq = 1'b0;
      m_lwm     = 0;
    end else begin
      n = m_q.size();
`ifdef UART_TX_FIFO_LWM_EN
      m_lwm_irq = (n <= m_lwm) && uart_enabled;
      if (lwm_we) m_lwm = int'(lwm_di);
`endif
      if (!flush && wr_en && n == DEPTH) m_ovf = 1'b1;
      else if (clr_ovf)                  m_ovf = 1'b0;
      if (flush) begin
        m_q.delete();
      end else begin
        if (n > 0 && uart_enabled && !uart_dat_wait) void'(m_q.pop_front());
        if (wr_en && n < DEPTH) m_q.push_back(wr_data);
      end
    end
  end

  // Monitor: compare every output against the model away from the active edge.
  always @(negedge clk) begin
    int n;
    n = m_q.size();
    check("level",    32'(level),    n);
    check("empty",    32'(empty),    32'(n == 0));
    check("full",     32'(full),     32'(n == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("lwm_irq",  32'(lwm_irq),  32'(m_lwm_irq));
    check("dat_we",   32'(uart_dat_we), 32'(n > 0 && uart_enabled));
    check("dat_di",   uart_dat_di, (n > 0) ? {24'h0, m_q[0]} : 32'h0);
    if (uart_dat_we && !uart_dat_wait) tx_log.push_back(uart_dat_di[7:0]);
  end

  initial begin
    resetn = 1'b0; uart_enabled = 1'b0; wr_en = 1'b0; wr_data = '0;
    flush = 1'b0; clr_ovf = 1'b0; lwm_we = 1'b0; lwm_di = '0; uart_dat_wait = 1'b0;
    repeat (3) step();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_dat_di", uart_dat_di, 32'h0);
    resetn = 1'b1;
    step();

    // Single byte through an idle FIFO.
    uart_enabled = 1'b1;
    tx_log.delete();
    push_byte(8'h55);
    check("t1_we_next", 32'(uart_dat_we), 32'd1);
    check("t1_di_next", uart_dat_di, 32'h55);
    step();
    check("t1_level0", 32'(level), 32'd0);
    check("t1_tx_cnt", tx_log.size(), 32'd1);
    if (tx_log.size() > 0) check("t1_tx_byte", 32'(tx_log[0]), 32'h55);

    // Fill to full, drop one, then drain in order.
    uart_dat_wait = 1'b1;
    tx_log.delete();
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    check("t2_full", 32'(full), 32'd1);
    check("t2_level", 32'(level), 32'd16);
    push_byte(8'hAA);
    check("t2_ovf", 32'(overflow), 32'd1);
    uart_dat_wait = 1'b0;
    repeat (DEPTH + 4) step();
    check("t2_tx_cnt", tx_log.size(), 32'd16);
    for (int i = 0; i < tx_log.size() && i < DEPTH; i++)
      check("t2_tx_order", 32'(tx_log[i]), i);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("t2_ovf_clr", 32'(overflow), 32'd0);

    // Steady level 8 with simultaneous push and pop, wrapping the pointers.
    uart_dat_wait = 1'b1;
    for (int i = 0; i < 8; i++) push_byte(8'(8'h80 + i));
    uart_dat_wait = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_data = 8'(8'hC0 + i);
      step();
    end
    wr_en = 1'b0;
    check("t3_level8", 32'(level), 32'd8);
    repeat (10) step();

    // Flush overrides a concurrent push.
    uart_dat_wait = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'(8'h10 + i));
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    step();
    flush = 1'b0; wr_en = 1'b0;
    check("t4_level0", 32'(level), 32'd0);
    check("t4_empty", 32'(empty), 32'd1);
    check("t4_ovf", 32'(overflow), 32'd0);
    uart_dat_wait = 1'b0;

    // Disabled UART freezes draining, pushes still land.
    uart_enabled = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(8'(8'h30 + i));
    repeat (2) step();
    check("t5_we_off", 32'(uart_dat_we), 32'd0);
    check("t5_level3", 32'(level), 32'd3);
    uart_enabled = 1'b1;
    #1;
    check("t5_we_on", 32'(uart_dat_we), 32'd1);
    step();
    check("t5_level2", 32'(level), 32'd2);
    repeat (4) step();

`ifdef UART_TX_FIFO_LWM_EN
    // Low-watermark interrupt edges.
    lwm_we = 1'b1; lwm_di = 2;
    step();
    lwm_we = 1'b0;
    uart_dat_wait = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(8'(8'h40 + i));
    step();
    check("t6_irq_lo", 32'(lwm_irq), 32'd0);
    uart_dat_wait = 1'b0;
    for (int i = 0; i < 8 && level != 2; i++) step();
    uart_dat_wait = 1'b1;
    check("t6_at2", 32'(level), 32'd2);
    check("t6_irq_pre", 32'(lwm_irq), 32'd0);
    step();
    check("t6_irq_rise", 32'(lwm_irq), 32'd1);
    for (int i = 0; i < 3; i++) push_byte(8'(8'h50 + i));
    step();
    check("t6_irq_fall", 32'(lwm_irq), 32'd0);
    uart_dat_wait = 1'b0;
    repeat (8) step();
`endif

    // Randomized traffic, with one asynchronous reset mid-run.
    for (int c = 0; c < 3000; c++) begin
      uart_enabled  = ($urandom_range(0, 9) != 0);
      uart_dat_wait = ($urandom_range(0, 2) == 0);
      wr_en         = ($urandom_range(0, 1) == 0);
      wr_data       = 8'($urandom);
      flush         = ($urandom_range(0, 63) == 0);
      clr_ovf       = ($urandom_range(0, 31) == 0);
`ifdef UART_TX_FIFO_LWM_EN
      lwm_we        = ($urandom_range(0, 99) == 0);
      lwm_di        = (DL+1)'($urandom_range(0, DEPTH));
`endif
      if (c == 1500) begin
        @(posedge clk);
        #3 resetn = 1'b0;
        #4;
        @(posedge clk);
        #1 resetn = 1'b1;
      end else begin
        step();
      end
    end
    wr_en = 1'b0; flush = 1'b0; clr_ovf = 1'b0; lwm_we = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
